// File: rtl/register_file_pkg.sv
// Shared types and helpers for the LVT-based multi-write-port register file.
package register_file_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_e;

   // An LVT entry must still have at least one bit when there is a single write port.
   function automatic int sel_width(input int write_ports);
      return (write_ports > 1) ? $clog2(write_ports) : 1;
   endfunction

   function automatic int bank_slice(input int bank, input int port, input int read_ports);
      return bank * read_ports + port;
   endfunction

endpackage

// File: rtl/register_file_lvt.sv
// Live-value table: for each register, the write port (bank) holding the newest value.
// Multiple write ports, asynchronous read ports, and a sweep port used for initialisation.
module register_file_lvt
   import register_file_pkg::*;
#(
   parameter int REG_COUNT   = 256,
   parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
   parameter int WRITE_PORTS = 4,
   parameter int READ_PORTS  = 8,
   parameter int SEL_WIDTH   = sel_width(WRITE_PORTS)
) (
   input  logic                              clk,
   input  logic                              sweep_we,
   input  logic [ADDR_WIDTH-1:0]             sweep_addr,
   input  logic [WRITE_PORTS-1:0]            wr_we,
   input  logic [ADDR_WIDTH*WRITE_PORTS-1:0] wr_addr,
   input  logic [ADDR_WIDTH*READ_PORTS-1:0]  rd_addr,
   output logic [SEL_WIDTH*READ_PORTS-1:0]   rd_sel
);

   logic [SEL_WIDTH-1:0] lvt_mem [REG_COUNT];

   // Writers arrive already de-conflicted; ascending order keeps the highest port as a backstop.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         lvt_mem[sweep_addr] <= '0;
      end else begin
         for (int i = 0; i < WRITE_PORTS; i++) begin
            if (wr_we[i]) begin
               lvt_mem[wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= SEL_WIDTH'(i);
            end
         end
      end
   end

   always_comb begin
      rd_sel = '0;
      for (int r = 0; r < READ_PORTS; r++) begin
         rd_sel[r*SEL_WIDTH +: SEL_WIDTH] = lvt_mem[rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      end
   end

endmodule

// File: rtl/register_file_lvt_ctrl.sv
// LVT controller: zero sweep after reset, write steering with collision priority,
// and latency-matched read selection across the per-write-port banks.
//
// state | meaning
// INIT  | sweeping bank 0 and the LVT to zero, traffic ignored, ready=0
// RUN   | normal traffic, ready=1
module register_file_lvt_ctrl
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int REG_COUNT   = 256,
   parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
   parameter int WRITE_PORTS = 4,
   parameter int READ_PORTS  = 8,
   parameter int RD_LATENCY  = 2,
   parameter int SEL_WIDTH   = sel_width(WRITE_PORTS)
) (
   input  logic                                         clk,
   input  logic                                         sync_rst_n,
   input  logic                                         clk_en,
   input  logic [WRITE_PORTS-1:0]                       wr_en,
   input  logic [ADDR_WIDTH*WRITE_PORTS-1:0]            wr_addr,
   input  logic [DATA_WIDTH*WRITE_PORTS-1:0]            wr_data,
   input  logic [READ_PORTS-1:0]                        rd_en,
   input  logic [ADDR_WIDTH*READ_PORTS-1:0]             rd_addr,
   output logic [WRITE_PORTS-1:0]                       bank_wr_en,
   output logic [ADDR_WIDTH*WRITE_PORTS-1:0]            bank_wr_addr,
   output logic [DATA_WIDTH*WRITE_PORTS-1:0]            bank_wr_data,
   output logic [ADDR_WIDTH*READ_PORTS-1:0]             bank_rd_addr,
   input  logic [DATA_WIDTH*READ_PORTS*WRITE_PORTS-1:0] bank_rd_data,
   output logic [DATA_WIDTH*READ_PORTS-1:0]             rd_data,
   output logic [READ_PORTS-1:0]                        rd_valid,
   output logic                                         ready,
   output logic [WRITE_PORTS-1:0]                       wr_conflict
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

   rf_state_e                       state_q, state_d;
   logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d;
   logic                            sweep_we;
   logic [WRITE_PORTS-1:0]          lvt_we;
   logic [WRITE_PORTS-1:0]          conflict;
   logic [SEL_WIDTH*READ_PORTS-1:0] lvt_sel;
   logic [READ_PORTS-1:0]           vld_pipe [RD_LATENCY];
   logic [SEL_WIDTH*READ_PORTS-1:0] sel_pipe [RD_LATENCY];

   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A lower port loses to any higher enabled port targeting the same address.
   always_comb begin
      conflict = '0;
      for (int i = 0; i < WRITE_PORTS; i++) begin
         for (int j = i + 1; j < WRITE_PORTS; j++) begin
            if (wr_en[i] && wr_en[j] &&
                wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
               conflict[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ready        = 1'b0;
      sweep_we     = 1'b0;
      lvt_we       = '0;
      bank_wr_en   = '0;
      bank_wr_addr = wr_addr;
      bank_wr_data = wr_data;
      case (state_q)
         INIT: begin
            cnt_d                        = cnt_q + ADDR_WIDTH'(1);
            sweep_we                     = sync_rst_n && clk_en;
            bank_wr_en[0]                = sweep_we;
            bank_wr_addr[ADDR_WIDTH-1:0] = cnt_q;
            bank_wr_data[DATA_WIDTH-1:0] = '0;
            if (cnt_q == LAST_ADDR) begin
               state_d = RUN;
            end
         end
         RUN: begin
            ready      = 1'b1;
            bank_wr_en = wr_en & ~conflict & {WRITE_PORTS{sync_rst_n && clk_en}};
            lvt_we     = bank_wr_en;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         wr_conflict <= '0;
      end else begin
         wr_conflict <= (clk_en && state_q == RUN) ? conflict : '0;
      end
   end

   register_file_lvt #(
      .REG_COUNT  (REG_COUNT),
      .ADDR_WIDTH (ADDR_WIDTH),
      .WRITE_PORTS(WRITE_PORTS),
      .READ_PORTS (READ_PORTS),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_lvt (
      .clk       (clk),
      .sweep_we  (sweep_we),
      .sweep_addr(cnt_q),
      .wr_we     (lvt_we),
      .wr_addr   (wr_addr),
      .rd_addr   (rd_addr),
      .rd_sel    (lvt_sel)
   );

   assign bank_rd_addr = rd_addr;

   // The selector is captured at the request edge, before that edge's writes land.
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         for (int k = 0; k < RD_LATENCY; k++) begin
            vld_pipe[k] <= '0;
            sel_pipe[k] <= '0;
         end
      end else if (clk_en) begin
         vld_pipe[0] <= rd_en & {READ_PORTS{state_q == RUN}};
         sel_pipe[0] <= lvt_sel;
         for (int k = 1; k < RD_LATENCY; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            sel_pipe[k] <= sel_pipe[k-1];
         end
      end
   end

   assign rd_valid = vld_pipe[RD_LATENCY-1];

   always_comb begin
      rd_data = '0;
      for (int r = 0; r < READ_PORTS; r++) begin
         if (rd_valid[r]) begin
            rd_data[r*DATA_WIDTH +: DATA_WIDTH] =
               bank_rd_data[bank_slice(int'(sel_pipe[RD_LATENCY-1][r*SEL_WIDTH +: SEL_WIDTH]),
                                       r, READ_PORTS)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_register_file_lvt_ctrl.sv
// Bench for register_file_lvt_ctrl: read-first bank model, register-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_register_file_lvt_ctrl;

   localparam int DW = 64;
   localparam int AW = 8;
   localparam int WP = 4;
   localparam int RP = 8;
   localparam int INIT_CYCLES = 256;

   logic              clk = 1'b0;
   logic              sync_rst_n;
   logic              clk_en;
   logic [WP-1:0]     wr_en;
   logic [AW*WP-1:0]  wr_addr;
   logic [DW*WP-1:0]  wr_data;
   logic [RP-1:0]     rd_en;
   logic [AW*RP-1:0]  rd_addr;
   logic [WP-1:0]     bank_wr_en;
   logic [AW*WP-1:0]  bank_wr_addr;
   logic [DW*WP-1:0]  bank_wr_data;
   logic [AW*RP-1:0]  bank_rd_addr;
   logic [DW*RP*WP-1:0] bank_rd_data;
   logic [DW*RP-1:0]  rd_data;
   logic [RP-1:0]     rd_valid;
   logic              ready;
   logic [WP-1:0]     wr_conflict;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   register_file_lvt_ctrl dut (
      .clk         (clk),
      .sync_rst_n  (sync_rst_n),
      .clk_en      (clk_en),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .bank_wr_en  (bank_wr_en),
      .bank_wr_addr(bank_wr_addr),
      .bank_wr_data(bank_wr_data),
      .bank_rd_addr(bank_rd_addr),
      .bank_rd_data(bank_rd_data),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .ready       (ready),
      .wr_conflict (wr_conflict)
   );

   // Read-first BRAM banks, two-stage read pipeline, held by clk_en.
   logic [DW-1:0] bmem [WP][256];
   logic [DW-1:0] bs1  [WP][RP];
   logic [DW-1:0] bs2  [WP][RP];

   always @(posedge clk) begin
      if (clk_en) begin
         for (int b = 0; b < WP; b++) begin
            for (int r = 0; r < RP; r++) begin
               bs1[b][r] <= bmem[b][bank_rd_addr[r*AW +: AW]];
               bs2[b][r] <= bs1[b][r];
            end
         end
      end
      for (int b = 0; b < WP; b++) begin
         if (bank_wr_en[b]) bmem[b][bank_wr_addr[b*AW +: AW]] <= bank_wr_data[b*DW +: DW];
      end
   end

   always_comb begin
      bank_rd_data = '0;
      for (int b = 0; b < WP; b++)
         for (int r = 0; r < RP; r++)
            bank_rd_data[(b*RP+r)*DW +: DW] = bs2[b][r];
   end

   // Reference model: a plain register array with read-before-write semantics.
   logic [DW-1:0] ref_mem [256];
   int            m_cnt = 0;
   logic [RP-1:0] m_v0 = '0, m_v1 = '0;
   logic [DW-1:0] m_d0 [RP];
   logic [DW-1:0] m_d1 [RP];
   logic [WP-1:0] m_conf = '0;
   bit            started = 1'b0;

   function automatic logic [WP-1:0] winners(input logic [WP-1:0] en, input logic [AW*WP-1:0] a);
      logic [255:0]  seen = '0;
      logic [WP-1:0] w = '0;
      for (int i = WP - 1; i >= 0; i--) begin
         if (en[i] && !seen[a[i*AW +: AW]]) begin
            w[i] = 1'b1;
            seen[a[i*AW +: AW]] = 1'b1;
         end
      end
      return w;
   endfunction

   task automatic model_step();
      logic          m_rdy;
      logic [WP-1:0] w;
      if (!sync_rst_n) begin
         started = 1'b1;
         m_cnt   = 0;
         m_v0    = '0;
         m_v1    = '0;
         m_conf  = '0;
         for (int a = 0; a < 256; a++) ref_mem[a] = '0;
         for (int r = 0; r < RP; r++) begin
            m_d0[r] = '0;
            m_d1[r] = '0;
         end
      end else if (clk_en) begin
         m_rdy = (m_cnt == INIT_CYCLES);
         m_v1  = m_v0;
         for (int r = 0; r < RP; r++) begin
            m_d1[r] = m_d0[r];
            m_v0[r] = m_rdy && rd_en[r];
            m_d0[r] = ref_mem[rd_addr[r*AW +: AW]];
         end
         m_conf = '0;
         if (m_rdy) begin
            w      = winners(wr_en, wr_addr);
            m_conf = wr_en & ~w;
            for (int i = 0; i < WP; i++)
               if (wr_en[i]) ref_mem[wr_addr[i*AW +: AW]] = wr_data[i*DW +: DW];
         end else begin
            m_cnt++;
         end
      end else begin
         m_conf = '0;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      logic [WP-1:0] exp_bwe;
      @(negedge clk);
      if (started) begin
         if (!sync_rst_n || !clk_en) exp_bwe = '0;
         else if (m_cnt != INIT_CYCLES) exp_bwe = 4'b0001;
         else exp_bwe = winners(wr_en, wr_addr);
         chk("ready", 64'(ready), 64'(m_cnt == INIT_CYCLES));
         chk("rd_valid", 64'(rd_valid), 64'(m_v1));
         chk("bank_wr_en", 64'(bank_wr_en), 64'(exp_bwe));
         chk("wr_conflict", 64'(wr_conflict), 64'(m_conf));
         for (int r = 0; r < RP; r++)
            chk($sformatf("rd_data[%0d]", r), rd_data[r*DW +: DW], m_v1[r] ? m_d1[r] : '0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = '0;
      rd_addr = '0;
   endtask

   task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
      wr_en[p]             = 1'b1;
      wr_addr[p*AW +: AW]  = AW'(a);
      wr_data[p*DW +: DW]  = d;
   endtask

   task automatic set_rd(input int p, input int a);
      rd_en[p]            = 1'b1;
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic count_init(input string name);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk(name, 64'(n), 64'(INIT_CYCLES));
   endtask

   initial begin
      sync_rst_n = 1'b0;
      clk_en     = 1'b1;
      idle();
      repeat (3) cyc();
      @(negedge clk);
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_valid", 64'(rd_valid), 64'd0);
      chk("reset_conflict", 64'(wr_conflict), 64'd0);
      cyc();
      sync_rst_n = 1'b1;
      count_init("init_len");

      // Every address reads zero after the sweep.
      for (int c = 0; c < 32; c++) begin
         cyc();
         for (int r = 0; r < RP; r++) set_rd(r, c * RP + r);
      end
      cyc();
      idle();
      repeat (3) cyc();

      // Single write then read on another port.
      set_wr(2, 5, 64'hAA);
      @(negedge clk);
      chk("single_bwe", 64'(bank_wr_en), 64'b0100);
      cyc();
      idle();
      set_rd(7, 5);
      cyc();
      idle();
      cyc();
      @(negedge clk);
      chk("single_valid7", 64'(rd_valid[7]), 64'd1);
      chk("single_data7", rd_data[7*DW +: DW], 64'hAA);

      // Three-way collision on address 9.
      cyc();
      set_wr(0, 9, 64'h1);
      set_wr(1, 9, 64'h2);
      set_wr(3, 9, 64'h3);
      @(negedge clk);
      chk("coll_bwe", 64'(bank_wr_en), 64'b1000);
      cyc();
      idle();
      @(negedge clk);
      chk("coll_mask", 64'(wr_conflict), 64'b0011);
      cyc();
      set_rd(0, 9);
      cyc();
      idle();
      cyc();
      @(negedge clk);
      chk("coll_read", rd_data[DW-1:0], 64'h3);

      // Same-cycle read and write returns the old value.
      cyc();
      set_wr(1, 4, 64'h11);
      cyc();
      idle();
      set_wr(0, 4, 64'h22);
      set_rd(3, 4);
      cyc();
      idle();
      set_rd(4, 4);
      cyc();
      idle();
      @(negedge clk);
      chk("rfw_old", rd_data[3*DW +: DW], 64'h11);
      cyc();
      @(negedge clk);
      chk("rfw_new", rd_data[4*DW +: DW], 64'h22);

      // Clock-enable stall with reads in flight.
      cyc();
      set_rd(0, 5);
      set_rd(1, 9);
      set_rd(2, 4);
      cyc();
      idle();
      set_rd(3, 5);
      for (int r = 4; r < RP; r++) set_rd(r, 100 + r);
      cyc();
      idle();
      clk_en = 1'b0;
      for (int i = 0; i < WP; i++) set_wr(i, 20 + i, 64'(i + 7));
      @(negedge clk);
      chk("stall_bwe", 64'(bank_wr_en), 64'd0);
      cyc();
      cyc();
      cyc();
      clk_en = 1'b1;
      idle();
      @(negedge clk);
      chk("stall_hold_valid", 64'(rd_valid), 64'h07);
      chk("stall_hold_data0", rd_data[DW-1:0], 64'hAA);
      chk("stall_hold_data2", rd_data[2*DW +: DW], 64'h22);
      cyc();
      @(negedge clk);
      chk("stall_done_valid", 64'(rd_valid), 64'hF8);
      chk("stall_done_data3", rd_data[3*DW +: DW], 64'hAA);

      // Reset in RUN drops in-flight reads; reset mid-sweep restarts it.
      cyc();
      set_rd(0, 5);
      cyc();
      idle();
      sync_rst_n = 1'b0;
      cyc();
      @(negedge clk);
      chk("rst_run_valid", 64'(rd_valid), 64'd0);
      chk("rst_run_ready", 64'(ready), 64'd0);
      cyc();
      sync_rst_n = 1'b1;
      repeat (100) cyc();
      sync_rst_n = 1'b0;
      cyc();
      sync_rst_n = 1'b1;
      count_init("reinit_len");
      cyc();
      set_rd(0, 5);
      cyc();
      idle();
      cyc();
      @(negedge clk);
      chk("wiped_valid", 64'(rd_valid[0]), 64'd1);
      chk("wiped_data", rd_data[DW-1:0], 64'd0);
      repeat (3) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/register_file_lvt_ctrl.md
# register_file_lvt_ctrl

Live-value-table (LVT) controller for the multi-write-port BRAM register file. It owns the per-register "which bank holds the newest value" table and steers writes into the per-write-port banks. It selects each read port's result from the correct bank with latency matched to the BRAM read pipeline. It also resolves same-address write collisions and sweeps the file to zero after reset before accepting traffic.

## Interface
- DATA_WIDTH, 64, register width
- REG_COUNT, 256, registers in the file
- ADDR_WIDTH, $clog2(REG_COUNT), register address width
- WRITE_PORTS, 4, write ports, one BRAM bank per port
- READ_PORTS, 8, read ports
- RD_LATENCY, 2, bank read latency in cycles (1 or 2)
- SEL_WIDTH, $clog2(WRITE_PORTS) (min 1), LVT entry width

Ports:
- clk  in  1  clock
- sync_rst_n  in  1  reset, synchronous, active-low
- clk_en  in  1  global clock enable
- wr_en  in  WRITE_PORTS  write request per port
- wr_addr  in  ADDR_WIDTH*WRITE_PORTS  write addresses, port i at slice i
- wr_data  in  DATA_WIDTH*WRITE_PORTS  write data
- rd_en  in  READ_PORTS  read request per port
- rd_addr  in  ADDR_WIDTH*READ_PORTS  read addresses
- bank_wr_en  out  WRITE_PORTS  write strobe to bank i
- bank_wr_addr  out  ADDR_WIDTH*WRITE_PORTS  bank write address
- bank_wr_data  out  DATA_WIDTH*WRITE_PORTS  bank write data
- bank_rd_addr  out  ADDR_WIDTH*READ_PORTS  read address, fanned to all banks
- bank_rd_data  in  DATA_WIDTH*READ_PORTS*WRITE_PORTS  bank b, read port r at slice b*READ_PORTS+r
- rd_data  out  DATA_WIDTH*READ_PORTS  selected read result
- rd_valid  out  READ_PORTS  rd_data slice valid
- ready  out  1  sweep done, traffic accepted
- wr_conflict  out  WRITE_PORTS  registered mask of suppressed write ports

## Operation
- FSM states: INIT and RUN. Reset enters INIT with sweep counter 0.
- INIT behaviour:
  - Each enabled cycle drives bank 0 with write of zero at the counter address and sets LVT[counter]=0.
  - Counter increments; after REG_COUNT-1 the FSM enters RUN.
  - External wr_en/rd_en are ignored. ready=0.
- RUN behaviour:
  - ready=1.
  - bank_wr_* is a combinational pass-through of wr_* gated by clk_en and the conflict mask.
  - Each surviving write sets LVT[wr_addr[i]]=i at the clock edge.
- Write collision: if two or more enabled ports share an address, the highest port index wins. Lower ports get bank_wr_en=0, and their bits are set in wr_conflict on the next cycle.
- Reads:
  - bank_rd_addr=rd_addr combinationally.
  - The LVT is read with rd_addr at the request edge, and the selector is delayed RD_LATENCY stages.
  - rd_data slice r is bank_rd_data[sel_r, r]; rd_valid is rd_en delayed RD_LATENCY stages.
  - rd_data is 0 when rd_valid is 0.
- Read and write to the same address in the same cycle returns the old value; the LVT lookup uses the pre-edge entry. The banks must be read-first.
- clk_en=0: FSM, counter, LVT and read pipeline hold; bank_wr_en=0.

## Timing
- Reset values: ready=0, rd_valid=0, rd_data=0, bank_wr_en=0, wr_conflict=0; the read pipeline is cleared. The LVT array has no reset; the sweep initialises it.
- INIT lasts exactly REG_COUNT enabled cycles. The first RUN cycle is the edge after counter=REG_COUNT-1.
- Reset asserted mid-INIT or mid-RUN restarts INIT at counter 0 and drops in-flight reads (rd_valid=0).
- Read latency: request at edge N gives rd_valid/rd_data in the cycle after edge N+RD_LATENCY-1, i.e. RD_LATENCY cycles. One request per port per cycle, fully pipelined.
- A write accepted at edge N is visible to a read issued at edge N+1.
- wr_conflict is valid one cycle after the colliding request and lasts one cycle.

## Structure
- Shared package register_file_pkg holds:
  - state enum rf_state_e {INIT, RUN}
  - SEL_WIDTH helper function
  - bank slice indexing function (bank, port to offset)
- Sub-module register_file_lvt: flop/LUTRAM table of REG_COUNT x SEL_WIDTH with WRITE_PORTS write ports, READ_PORTS asynchronous read ports and one sweep write port. No reset.
- The controller instantiates the LVT and contains the FSM, conflict priority logic, selector/valid delay lines and output mux.

## Test plan
- Reset then idle: ready=0 for exactly 256 cycles, then 1. A sweep of 256 reads to every address returns 0.
- After ready, write port 2 addr 5 = 0xAA, then read port 7 addr 5 next cycle: rd_data[7]=0xAA and rd_valid[7] two cycles later. bank_wr_en=4'b0100.
- Ports 0,1,3 write addr 9 with 0x1,0x2,0x3 in one cycle: only bank_wr_en[3], wr_conflict=4'b0011 next cycle, subsequent read addr 9 = 0x3.
- Addr 4 holds 0x11; write 0x22 and read addr 4 in the same cycle: the read returns 0x11, and a read one cycle later returns 0x22.
- clk_en low for 3 cycles with reads in flight: rd_valid/rd_data hold, no bank writes. Reads complete after clk_en returns, with total latency of 2 enabled cycles.
- Reset pulsed at sweep counter 100: ready stays 0 for a full 256 cycles after release, and in-flight rd_valid is cleared.
